// File: rtl/prach_pkg.sv
// Shared constants, phase type and scaling helpers for the PRACH DFT stages.
package prach_pkg;

    localparam int SW = 18;

    localparam logic signed [SW:0] SAT_MAX = 19'sd131071;
    localparam logic signed [SW:0] SAT_MIN = -19'sd131072;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2
    } phase_t;

    function automatic logic signed [SW-1:0] sat19to18(input logic signed [SW:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[SW-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[SW-1:0];
        else
            return v[SW-1:0];
    endfunction

    // Round half up, then clamp: only v = 262143 can reach +131072.
    function automatic logic signed [SW-1:0] rnd_half(input logic signed [SW:0] v);
        logic signed [SW+1:0] t;
        t = {v[SW], v} + 20'sd1;
        return sat19to18(t[SW+1:1]);
    endfunction

endpackage

// File: rtl/prach_ditfft3_bf3_delay.sv
// Generic fixed-length shift-register delay line.
module prach_ditfft3_bf3_delay #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++)
                sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DELAY; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DELAY-1];

endmodule

// File: rtl/prach_ditfft3_bf3.sv
// Final radix-3 DIT butterfly: X0 = y0, X1 = y1 - y2, X2 = y1 + y2.
module prach_ditfft3_bf3
    import prach_pkg::*;
#(
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [SW-1:0] din_dr,
    input  logic signed [SW-1:0] din_di,
    input  logic                 din_dv,
    input  logic                 sync_in,
    output logic signed [SW-1:0] dout_dr,
    output logic signed [SW-1:0] dout_di,
    output logic                 dout_dv,
    output logic                 sync_out,
    output logic                 err_sync
);

    phase_t in_ph, in_nxt;
    phase_t out_ph, out_nxt;

    logic signed [SW-1:0] y1r, y1i;
    logic signed [SW:0]   dif_r, dif_i, sum_r, sum_i;
    logic [2*SW+1:0]      dly_out;
    logic [1:0]           ctl_d2;
    logic signed [SW:0]   sel_r, sel_i;
    logic signed [SW-1:0] scl_r, scl_i;
    logic                 unused_dly;

    prach_ditfft3_bf3_delay #(
        .WIDTH (2*SW+2),
        .DELAY (2)
    ) u_dly_y0 (
        .clk   (clk),
        .rst_n (1'b1),
        .din   ({sync_in, din_dv, din_dr, din_di}),
        .dout  (dly_out)
    );

    // Framing comes from the reset copy so nothing stale leaves after reset.
    prach_ditfft3_bf3_delay #(
        .WIDTH (2),
        .DELAY (2)
    ) u_dly_ctl (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({sync_in, din_dv}),
        .dout  (ctl_d2)
    );

    assign unused_dly = ^dly_out[2*SW+1:2*SW];

    always_comb begin
        in_nxt = IDLE;
        if (sync_in) begin
            in_nxt = P1;
        end else begin
            unique case (in_ph)
                P1:      in_nxt = P2;
                default: in_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_ph == P1) begin
            y1r <= din_dr;
            y1i <= din_di;
        end
        if (in_ph == P2) begin
            dif_r <= {y1r[SW-1], y1r} - {din_dr[SW-1], din_dr};
            dif_i <= {y1i[SW-1], y1i} - {din_di[SW-1], din_di};
            sum_r <= {y1r[SW-1], y1r} + {din_dr[SW-1], din_dr};
            sum_i <= {y1i[SW-1], y1i} + {din_di[SW-1], din_di};
        end
    end

    always_comb begin
        out_nxt = IDLE;
        sel_r   = {dly_out[2*SW-1], dly_out[2*SW-1:SW]};
        sel_i   = {dly_out[SW-1], dly_out[SW-1:0]};
        if (ctl_d2[1]) begin
            out_nxt = P1;
        end else begin
            unique case (out_ph)
                P1: begin
                    sel_r   = dif_r;
                    sel_i   = dif_i;
                    out_nxt = P2;
                end
                P2: begin
                    sel_r   = sum_r;
                    sel_i   = sum_i;
                    out_nxt = IDLE;
                end
                default: out_nxt = IDLE;
            endcase
        end
    end

    assign scl_r = (SCALE != 0) ? rnd_half(sel_r) : sat19to18(sel_r);
    assign scl_i = (SCALE != 0) ? rnd_half(sel_i) : sat19to18(sel_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ph    <= IDLE;
            out_ph   <= IDLE;
            err_sync <= 1'b0;
            sync_out <= 1'b0;
            dout_dv  <= 1'b0;
            dout_dr  <= '0;
            dout_di  <= '0;
        end else begin
            in_ph    <= in_nxt;
            out_ph   <= out_nxt;
            err_sync <= sync_in && (in_ph != IDLE);
            sync_out <= ctl_d2[1];
            dout_dv  <= ctl_d2[0];
            dout_dr  <= scl_r;
            dout_di  <= scl_i;
        end
    end

endmodule

// File: tb/tb_prach_ditfft3_bf3.sv
// Scoreboard bench for prach_ditfft3_bf3, SCALE=0 and SCALE=1 side by side.
module tb_prach_ditfft3_bf3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [17:0] din_dr, din_di;
    logic din_dv, sync_in;

    logic signed [17:0] d0_r, d0_i, d1_r, d1_i;
    logic d0_dv, d0_so, d0_err, d1_dv, d1_so, d1_err;

    always #5 clk = ~clk;

    prach_ditfft3_bf3 #(.SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .din_dr(din_dr), .din_di(din_di),
        .din_dv(din_dv), .sync_in(sync_in),
        .dout_dr(d0_r), .dout_di(d0_i),
        .dout_dv(d0_dv), .sync_out(d0_so),
        .err_sync(d0_err)
    );

    prach_ditfft3_bf3 #(.SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .din_dr(din_dr), .din_di(din_di),
        .din_dv(din_dv), .sync_in(sync_in),
        .dout_dr(d1_r), .dout_di(d1_i),
        .dout_dv(d1_dv), .sync_out(d1_so),
        .err_sync(d1_err)
    );

    typedef struct {
        int cyc;
        bit sync;
        bit chk;
        int r0, i0, r1, i1;
    } exp_t;

    typedef int v6_t[6];

    exp_t q[$];
    exp_t m_e;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int err_exp_cyc = -1;
    int err_cnt0 = 0;
    int err_cnt1 = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (d0_err) begin
                err_cnt0++;
                check("err_sync0 cycle", cyc, err_exp_cyc);
            end
            if (d1_err) begin
                err_cnt1++;
                check("err_sync1 cycle", cyc, err_exp_cyc);
            end
            if (d0_dv || d1_dv) begin
                if (q.size() == 0) begin
                    check("unexpected dout_dv0", int'(d0_dv), 0);
                    check("unexpected dout_dv1", int'(d1_dv), 0);
                end else begin
                    m_e = q.pop_front();
                    check("dout_dv0", int'(d0_dv), 1);
                    check("dout_dv1", int'(d1_dv), 1);
                    check("latency", cyc, m_e.cyc);
                    check("sync_out0", int'(d0_so), int'(m_e.sync));
                    check("sync_out1", int'(d1_so), int'(m_e.sync));
                    if (m_e.chk) begin
                        check("s0 real", int'(d0_r), m_e.r0);
                        check("s0 imag", int'(d0_i), m_e.i0);
                        check("s1 real", int'(d1_r), m_e.r1);
                        check("s1 imag", int'(d1_i), m_e.i1);
                    end
                end
            end
        end
    end

    function automatic int sat(input int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int rnd(input int v);
        return sat((v + 1) >>> 1);
    endfunction

    task automatic drive(input bit s, input bit v, input int r, input int i,
                         input bit push, input exp_t e);
        sync_in = s;
        din_dv  = v;
        din_dr  = r[17:0];
        din_di  = i[17:0];
        if (push) begin
            e.cyc = cyc + 3;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        exp_t e;
        e = '{default: 0};
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, 0, 0, 1'b0, e);
    endtask

    task automatic group(input v6_t y, input v6_t e0, input v6_t e1);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.sync = (k == 0);
            e.chk  = 1'b1;
            e.r0   = e0[2*k];
            e.i0   = e0[2*k+1];
            e.r1   = e1[2*k];
            e.i1   = e1[2*k+1];
            drive(k == 0, 1'b1, y[2*k], y[2*k+1], 1'b1, e);
        end
    endtask

    task automatic model(input v6_t y, output v6_t e0, output v6_t e1);
        int x[6];
        x[0] = y[0];
        x[1] = y[1];
        x[2] = y[2] - y[4];
        x[3] = y[3] - y[5];
        x[4] = y[2] + y[4];
        x[5] = y[3] + y[5];
        for (int k = 0; k < 6; k++) begin
            e0[k] = sat(x[k]);
            e1[k] = rnd(x[k]);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " d0_r"}, int'(d0_r), 0);
        check({tag, " d0_i"}, int'(d0_i), 0);
        check({tag, " d0_dv"}, int'(d0_dv), 0);
        check({tag, " d0_so"}, int'(d0_so), 0);
        check({tag, " d0_err"}, int'(d0_err), 0);
        check({tag, " d1_r"}, int'(d1_r), 0);
        check({tag, " d1_i"}, int'(d1_i), 0);
        check({tag, " d1_dv"}, int'(d1_dv), 0);
        check({tag, " d1_so"}, int'(d1_so), 0);
        check({tag, " d1_err"}, int'(d1_err), 0);
    endtask

    v6_t y, e0, e1;
    logic signed [17:0] rv;
    exp_t te;
    int tmo;

    initial begin
        sync_in = 1'b0;
        din_dv  = 1'b0;
        din_dr  = '0;
        din_di  = '0;
        te      = '{default: 0};
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        idle(2);

        group('{1000, 0, 300, 50, -200, 20},
              '{1000, 0, 500, 30, 100, 70},
              '{500, 0, 250, 15, 50, 35});
        idle(4);

        group('{0, 0, 131071, 0, -131071, -131072},
              '{0, 0, 131071, 131071, 0, -131072},
              '{0, 0, 131071, 65536, 0, -65536});
        group('{7, -5, 3, 0, 0, 0},
              '{7, -5, 3, 0, 3, 0},
              '{4, -2, 2, 0, 2, 0});
        idle(4);

        for (int g = 0; g < 100; g++) begin
            for (int k = 0; k < 6; k++) begin
                rv   = 18'($urandom);
                y[k] = int'(rv);
            end
            model(y, e0, e1);
            group(y, e0, e1);
        end
        idle(6);

        te.sync = 1'b1;
        te.chk  = 1'b0;
        drive(1'b1, 1'b1, 11, 22, 1'b1, te);
        err_exp_cyc = cyc + 1;
        group('{1000, 0, 300, 50, -200, 20},
              '{1000, 0, 500, 30, 100, 70},
              '{500, 0, 250, 15, 50, 35});
        idle(6);

        te = '{default: 0};
        drive(1'b1, 1'b1, 9, 9, 1'b0, te);
        drive(1'b0, 1'b1, 8, 8, 1'b0, te);
        sync_in = 1'b0;
        din_dv  = 1'b1;
        din_dr  = 18'sd5;
        din_di  = 18'sd5;
        rst_n   = 1'b0;
        #1;
        chk_zero("mid-group reset");
        @(posedge clk);
        #1;
        chk_zero("held reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        group('{-40, 60, 300, 50, -200, 20},
              '{-40, 60, 500, 30, 100, 70},
              '{-20, 30, 250, 15, 50, 35});
        idle(8);

        tmo = 0;
        while (q.size() > 0 && tmo < 50) begin
            @(posedge clk);
            tmo++;
        end
        check("scoreboard drained", q.size(), 0);
        check("err_sync0 pulses", err_cnt0, 1);
        check("err_sync1 pulses", err_cnt1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
